// File: rtl/peak_pkg.sv
// ============================================================================
// Module      : peak_pkg
// Description : Shared state encoding and default parameters for peak_hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package peak_pkg;

    localparam int W_DEF  = 8;
    localparam int HW_DEF = 16;
    localparam int DS_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

endpackage : peak_pkg

`default_nettype wire

// File: rtl/mag_sat.sv
// ============================================================================
// Module      : mag_sat
// Description : Registered magnitude of a signed sample; most-negative code
//               saturates to the largest positive magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mag_sat
    import peak_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] sig_i,
    input  logic                vld_i,
    output logic        [W-2:0] mag_o,
    output logic                vld_o,
    output logic                sat_o
);

    logic [W-2:0] w_low;
    logic [W-2:0] w_neg;
    logic [W-2:0] mag_d;
    logic [W-2:0] mag_q;
    logic         vld_q;

    // For every negative code except the minimum, |x| fits in W-1 bits, so
    // negating just the low bits modulo 2^(W-1) gives the magnitude.
    assign w_low = sig_i[W-2:0];
    assign w_neg = ~w_low + (W-1)'(1);
    assign sat_o = sig_i[W-1] && (w_low == '0);

    always_comb begin
        mag_d = w_low;
        if (sat_o) begin
            mag_d = '1;
        end else if (sig_i[W-1]) begin
            mag_d = w_neg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_q <= '0;
            vld_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            vld_q <= vld_i;
        end
    end

    assign mag_o = mag_q;
    assign vld_o = vld_q;

endmodule : mag_sat

`default_nettype wire

// File: rtl/peak_hold.sv
// ============================================================================
// Module      : peak_hold
// Description : Peak magnitude detector with programmable hold and
//               shift-based exponential decay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peak_hold
    import peak_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int HW = HW_DEF,
    parameter int DS = DS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  sig,
    input  logic                 vld,
    input  logic        [HW-1:0] hold,
    input  logic                 clr,
    output logic        [W-2:0]  max,
    output logic                 pk,
    output logic                 ovf
);

    logic [W-2:0]  mag_q;
    logic          vld_q;
    logic          w_sat;

    state_t        state_q, state_d;
    logic [W-2:0]  max_q, max_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic          pk_q, pk_d;
    logic          ovf_q, ovf_d;

    logic [W-2:0]  w_shr;
    logic [W-2:0]  w_step;
    logic [W-2:0]  w_sub;
    logic [W-2:0]  w_dec;

    mag_sat #(
        .W(W)
    ) u_mag_sat (
        .clk   (clk),
        .rst   (rst),
        .sig_i (sig),
        .vld_i (vld),
        .mag_o (mag_q),
        .vld_o (vld_q),
        .sat_o (w_sat)
    );

    // One decay step never drops below the incoming magnitude.
    assign w_shr  = max_q >> DS;
    assign w_step = (w_shr == '0) ? (W-1)'(1) : w_shr;
    assign w_sub  = (max_q > w_step) ? (max_q - w_step) : '0;
    assign w_dec  = (w_sub > mag_q) ? w_sub : mag_q;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        pk_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ST_IDLE;
            max_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (vld_q) begin
            if (mag_q > max_q) begin
                max_d   = mag_q;
                cnt_d   = hold;
                pk_d    = 1'b1;
                state_d = ST_HOLD;
            end else if (mag_q == max_q) begin
                if (state_q != ST_IDLE) begin
                    cnt_d   = hold;
                    state_d = ST_HOLD;
                end
            end else if ((state_q == ST_HOLD) && (cnt_q != '0)) begin
                cnt_d = cnt_q - HW'(1);
            end else begin
                max_d   = w_dec;
                state_d = (w_dec == '0) ? ST_IDLE : ST_DECAY;
            end
        end
        // A saturating sample outranks a simultaneous clear.
        if (vld && w_sat) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            max_q   <= '0;
            cnt_q   <= '0;
            pk_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            pk_q    <= pk_d;
            ovf_q   <= ovf_d;
        end
    end

    assign max = max_q;
    assign pk  = pk_q;
    assign ovf = ovf_q;

endmodule : peak_hold

`default_nettype wire

// File: doc/peak_hold.md
PEAK_HOLD -- requirements
Module: peak_hold

Interface
REQ-001 Parameter W, default 8: signed input width, W >= 4.
REQ-002 Parameter HW, default 16: hold-counter width.
REQ-003 Parameter DS, default 3: decay shift; per-step decay is max>>DS, minimum 1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 sig  in  W  two's-complement input sample.
REQ-007 vld  in  1  sample strobe; sig is taken on clock edges where vld=1.
REQ-008 hold  in  HW  hold time, counted in valid samples; sampled when a new peak is loaded.
REQ-009 clr  in  1  synchronous clear.
REQ-010 max  out  W-1  held peak magnitude, unsigned.
REQ-011 pk  out  1  one-cycle pulse when max is loaded with a strictly larger value.
REQ-012 ovf  out  1  sticky flag: a sample equal to -2^(W-1) has been seen.

Function
REQ-013 Stage 1 shall register mag = |sig| and vld_d on every edge; -2^(W-1) saturates to 2^(W-1)-1 and sets ovf on the same edge.
REQ-014 Stage 2 shall act only when vld_d=1, so max and pk change 2 clocks after the sampling edge.
REQ-015 States: IDLE (max=0), HOLD, DECAY; encoding 2 bits.
REQ-016 Any state, mag > max: max<=mag, cnt<=hold, pk<=1, next state HOLD.
REQ-017 HOLD or DECAY, mag == max: cnt<=hold, next state HOLD, pk=0.
REQ-018 HOLD, mag < max, cnt != 0: cnt<=cnt-1, max unchanged.
REQ-019 HOLD, mag < max, cnt == 0: apply one decay step (REQ-020), next state DECAY; hold=0 therefore decays on the first smaller sample.
REQ-020 DECAY step: d = max>>DS, or 1 if that is 0; max <= greater of (max-d, clamped at 0) and mag.
REQ-021 When a decay step yields max=0, next state IDLE.
REQ-022 IDLE, mag=0: no change; pk never pulses for mag=0.
REQ-023 clr=1 shall set max=0, cnt=0, ovf=0, pk=0, state IDLE, and discard any stage-2 sample in the same cycle.
REQ-024 clr shall not affect stage 1; a sample taken on the clr edge is processed normally on the next edge.
REQ-025 clr and a -2^(W-1) sample on the same edge: ovf ends at 1, because the set takes priority over the clear.
REQ-026 Widths: no wrap in any arithmetic; max never exceeds 2^(W-1)-1; cnt never underflows.

Reset
REQ-027 rst=0 shall immediately force max=0, pk=0, ovf=0, mag=0, vld_d=0, cnt=0, state IDLE, without waiting for a clock edge.
REQ-028 Reset asserted mid-HOLD or mid-DECAY shall lose all peak history; the first valid sample after release follows the REQ-016 path.
REQ-029 Release of rst shall be synchronised externally; the block adds no synchroniser.

Structure
REQ-030 State encodings (IDLE=0, HOLD=1, DECAY=2) shall live in the shared package peak_pkg, with the default-parameter constants.
REQ-031 Stage 1 shall be the sub-module mag_sat (W-bit signed in, W-1-bit magnitude out, sat flag out).
REQ-032 All other logic stays in peak_hold; no memories, one clock domain.

Verification (W=8, DS=3)
REQ-033 Reset: drive rst low during HOLD with max=64 -> max=0, pk=0 and ovf=0 immediately, before the next clock edge.
REQ-034 Ramp: sig=1..8 with vld every clock, hold=4 -> max=1..8 lagging by 2 clocks, pk high each of those 8 cycles.
REQ-035 Saturation: sig=-128 -> max=127 and ovf=1; ovf stays 1 through later samples until clr; sig=-127 -> max=127, ovf unchanged.
REQ-036 Hold/decay: peak 64, then sig=0 with hold=4 -> max=64 for 4 further samples, then 56, 49, 43, 38 ...; steps of 1 below 8; state IDLE at 0.
REQ-037 Recapture: during decay at max=49, sig=50 -> max=50, pk=1, state HOLD, cnt reloaded; sig=49 at max=49 -> no pk, hold reloaded.
REQ-038 clr race: vld with sig=100 on edge k, clr=1 on edge k+1 -> max=0 after k+1, pk never pulses; vld with sig=20 on edge k+1 -> max=20 after k+2.
